// File: rtl/bram_pkg.sv
// Shared types and helpers for the simple-dual-port byte-enable block RAM.
// Index range checks are done on the full shifted address before truncation.
package bram_pkg;

   typedef enum logic {
      COL_OLD = 1'b0,
      COL_NEW = 1'b1
   } collision_t;

   function automatic int unsigned bytes_of(input int unsigned width);
      return width / 8;
   endfunction

   function automatic logic idx_in_range(input logic [31:0] addr,
                                         input int unsigned lsh,
                                         input int unsigned size);
      return (addr >> lsh) < size;
   endfunction

endpackage

// File: rtl/bram_bypass_merge.sv
// Registered write-forwarding for same-index read/write collisions.
// Captures hit/wdata/byteen alongside the array read and merges bytes at the array output.
module bram_bypass_merge import bram_pkg::*; #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_capture,
   input  logic                  i_hit,
   input  logic [WIDTH-1:0]      i_wdata,
   input  logic [WIDTH/8-1:0]    i_byteen,
   input  logic [WIDTH-1:0]      i_ram_data,
   output logic [WIDTH-1:0]      o_data
);

   localparam int unsigned BYTES = bytes_of(WIDTH);

   logic             hit_q;
   logic [WIDTH-1:0] wdata_q;
   logic [BYTES-1:0] byteen_q;

   // Only accepted in-range reads update the capture, so the merged word holds between reads.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hit_q    <= 1'b0;
         wdata_q  <= '0;
         byteen_q <= '0;
      end else if (i_capture) begin
         hit_q <= i_hit;
         if (i_hit) begin
            wdata_q  <= i_wdata;
            byteen_q <= i_byteen;
         end
      end
   end

   always_comb begin
      o_data = i_ram_data;
      for (int b = 0; b < BYTES; b++) begin
         if (hit_q && byteen_q[b]) begin
            o_data[8*b +: 8] = wdata_q[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/bram_1r1w_be.sv
// Simple-dual-port block RAM: one read port, one byte-enabled write port, bounds checking,
// 1- or 2-cycle read latency and selectable read/write collision behaviour.
module bram_1r1w_be import bram_pkg::*; #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SIZE      = 32'h400,
   parameter int unsigned ADDR_LSH  = 2,
   parameter int unsigned OUT_REG   = 0,
   parameter collision_t  COLLISION = COL_NEW
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_pa_request,
   input  logic [31:0]           i_pa_address,
   output logic [WIDTH-1:0]      o_pa_rdata,
   output logic                  o_pa_ready,
   output logic                  o_pa_error,
   input  logic                  i_pb_request,
   input  logic [31:0]           i_pb_address,
   input  logic [WIDTH-1:0]      i_pb_wdata,
   input  logic [WIDTH/8-1:0]    i_pb_byteen,
   output logic                  o_pb_ready,
   output logic                  o_pb_error
);

   localparam int unsigned BYTES = bytes_of(WIDTH);
   localparam int unsigned IW    = (SIZE > 1) ? $clog2(SIZE) : 1;

   (* ram_style = "block" *) logic [WIDTH-1:0] mem [SIZE];

   logic          rd_in_range, wr_in_range;
   logic [IW-1:0] rd_idx, wr_idx;
   logic          rd_fire, wr_fire, wr_en;

   logic             rd_valid_q, rd_err_q;
   logic [WIDTH-1:0] ram_q;
   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] stage1_data;
   logic             pb_ready_q, pb_error_q;

   always_comb begin
      rd_in_range = idx_in_range(i_pa_address, ADDR_LSH, SIZE);
      wr_in_range = idx_in_range(i_pb_address, ADDR_LSH, SIZE);
      rd_idx      = IW'(i_pa_address >> ADDR_LSH);
      wr_idx      = IW'(i_pb_address >> ADDR_LSH);
      rd_fire     = i_pa_request & rd_in_range;
      wr_fire     = i_pb_request & wr_in_range;
      // Writes sampled during reset are dropped; the array itself is never cleared.
      wr_en       = wr_fire & i_reset_n;
   end

   always_ff @(posedge i_clock) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (i_pb_byteen[b]) begin
               mem[wr_idx][8*b +: 8] <= i_pb_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         ram_q      <= '0;
         pb_ready_q <= 1'b0;
         pb_error_q <= 1'b0;
      end else begin
         rd_valid_q <= i_pa_request;
         if (i_pa_request) begin
            rd_err_q <= ~rd_in_range;
         end
         // Read-before-write: a same-edge write is not visible in ram_q.
         if (rd_fire) begin
            ram_q <= mem[rd_idx];
         end
         pb_ready_q <= i_pb_request;
         pb_error_q <= i_pb_request & ~wr_in_range;
      end
   end

   assign o_pb_ready = pb_ready_q;
   assign o_pb_error = pb_error_q;

   if (COLLISION == COL_NEW) begin : g_bypass
      logic hit;
      assign hit = rd_fire & wr_fire & (rd_idx == wr_idx);

      bram_bypass_merge #(
         .WIDTH (WIDTH)
      ) u_bypass (
         .i_clock    (i_clock),
         .i_reset_n  (i_reset_n),
         .i_capture  (rd_fire),
         .i_hit      (hit),
         .i_wdata    (i_pb_wdata),
         .i_byteen   (i_pb_byteen),
         .i_ram_data (ram_q),
         .o_data     (merged)
      );
   end else begin : g_no_bypass
      assign merged = ram_q;
   end

   assign stage1_data = rd_err_q ? '0 : merged;

   if (OUT_REG != 0) begin : g_out_reg
      logic             out_valid_q, out_err_q;
      logic [WIDTH-1:0] out_data_q;

      always_ff @(posedge i_clock or negedge i_reset_n) begin
         if (!i_reset_n) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= '0;
         end else begin
            out_valid_q <= rd_valid_q;
            out_err_q   <= rd_valid_q & rd_err_q;
            if (rd_valid_q) begin
               out_data_q <= stage1_data;
            end
         end
      end

      assign o_pa_ready = out_valid_q;
      assign o_pa_error = out_err_q;
      assign o_pa_rdata = out_data_q;
   end else begin : g_no_out_reg
      assign o_pa_ready = rd_valid_q;
      assign o_pa_error = rd_valid_q & rd_err_q;
      assign o_pa_rdata = stage1_data;
   end

endmodule

// File: tb/tb_bram_1r1w_be.sv
// Directed bench: dut0 is OUT_REG=0/COL_OLD, dut1 is OUT_REG=1/COL_NEW, both on shared stimulus.
module tb_bram_1r1w_be;
   import bram_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pa_req;
   logic [31:0] pa_addr;
   logic        pb_req;
   logic [31:0] pb_addr;
   logic [31:0] pb_wdata;
   logic [3:0]  pb_be;

   logic [31:0] rdata0, rdata1;
   logic        ready0, ready1, err0, err1;
   logic        pb_ready0, pb_ready1, pb_err0, pb_err1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bram_1r1w_be #(
      .WIDTH     (32),
      .SIZE      (32'h400),
      .ADDR_LSH  (2),
      .OUT_REG   (0),
      .COLLISION (COL_OLD)
   ) dut0 (
      .i_clock      (clk),
      .i_reset_n    (rst_n),
      .i_pa_request (pa_req),
      .i_pa_address (pa_addr),
      .o_pa_rdata   (rdata0),
      .o_pa_ready   (ready0),
      .o_pa_error   (err0),
      .i_pb_request (pb_req),
      .i_pb_address (pb_addr),
      .i_pb_wdata   (pb_wdata),
      .i_pb_byteen  (pb_be),
      .o_pb_ready   (pb_ready0),
      .o_pb_error   (pb_err0)
   );

   bram_1r1w_be #(
      .WIDTH     (32),
      .SIZE      (32'h400),
      .ADDR_LSH  (2),
      .OUT_REG   (1),
      .COLLISION (COL_NEW)
   ) dut1 (
      .i_clock      (clk),
      .i_reset_n    (rst_n),
      .i_pa_request (pa_req),
      .i_pa_address (pa_addr),
      .o_pa_rdata   (rdata1),
      .o_pa_ready   (ready1),
      .o_pa_error   (err1),
      .i_pb_request (pb_req),
      .i_pb_address (pb_addr),
      .i_pb_wdata   (pb_wdata),
      .i_pb_byteen  (pb_be),
      .o_pb_ready   (pb_ready1),
      .o_pb_error   (pb_err1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one set of requests for a single edge, then drop the strobes.
   task automatic drive(input logic rq, input logic [31:0] ra, input logic wq,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be);
      pa_req   = rq;
      pa_addr  = ra;
      pb_req   = wq;
      pb_addr  = wa;
      pb_wdata = wd;
      pb_be    = be;
      tick();
      pa_req = 1'b0;
      pb_req = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b1;
      pa_req   = 1'b0;
      pa_addr  = '0;
      pb_req   = 1'b0;
      pb_addr  = '0;
      pb_wdata = '0;
      pb_be    = '0;
      #2 rst_n = 1'b0;
      tick();
      check("rst ready0", 32'(ready0), 32'd0);
      check("rst err0", 32'(err0), 32'd0);
      check("rst rdata0", rdata0, 32'd0);
      check("rst pb_ready0", 32'(pb_ready0), 32'd0);
      check("rst pb_err0", 32'(pb_err0), 32'd0);
      check("rst ready1", 32'(ready1), 32'd0);
      check("rst rdata1", rdata1, 32'd0);
      #3 rst_n = 1'b1;
      tick();

      // Full-word write then read
      drive(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      check("t1 pb_ready0", 32'(pb_ready0), 32'd1);
      check("t1 pb_err0", 32'(pb_err0), 32'd0);
      check("t1 pb_ready1", 32'(pb_ready1), 32'd1);
      drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
      check("t1 pb_ready0 pulse", 32'(pb_ready0), 32'd0);
      check("t1 ready0", 32'(ready0), 32'd1);
      check("t1 rdata0", rdata0, 32'hDEADBEEF);
      check("t1 err0", 32'(err0), 32'd0);
      check("t1 ready1 early", 32'(ready1), 32'd0);
      tick();
      check("t1 ready1", 32'(ready1), 32'd1);
      check("t1 rdata1", rdata1, 32'hDEADBEEF);
      check("t1 ready0 pulse", 32'(ready0), 32'd0);
      check("t1 rdata0 hold", rdata0, 32'hDEADBEEF);

      // Partial byte-enable write
      drive(1'b0, 32'h0, 1'b1, 32'h14, 32'h11223344, 4'hF);
      drive(1'b0, 32'h0, 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101);
      drive(1'b1, 32'h14, 1'b0, 32'h0, 32'h0, 4'h0);
      check("t2 rdata0", rdata0, 32'h11BB33DD);
      tick();
      check("t2 ready1", 32'(ready1), 32'd1);
      check("t2 rdata1", rdata1, 32'h11BB33DD);

      // Same-edge collision, then a write one edge after a read
      drive(1'b0, 32'h0, 1'b1, 32'h1C, 32'h00000000, 4'hF);
      drive(1'b1, 32'h1C, 1'b1, 32'h1C, 32'hCAFEF00D, 4'b1100);
      check("t3 ready0", 32'(ready0), 32'd1);
      check("t3 col_old rdata0", rdata0, 32'h00000000);
      check("t3 pb_ready0", 32'(pb_ready0), 32'd1);
      tick();
      check("t3 ready1", 32'(ready1), 32'd1);
      check("t3 col_new rdata1", rdata1, 32'hCAFE0000);
      drive(1'b1, 32'h1C, 1'b0, 32'h0, 32'h0, 4'h0);
      check("t3 after rdata0", rdata0, 32'hCAFE0000);
      drive(1'b0, 32'h0, 1'b1, 32'h1C, 32'hFFFFFFFF, 4'hF);
      check("t3 late write ready1", 32'(ready1), 32'd1);
      check("t3 late write rdata1", rdata1, 32'hCAFE0000);
      drive(1'b1, 32'h1C, 1'b0, 32'h0, 32'h0, 4'h0);
      check("t3 new word rdata0", rdata0, 32'hFFFFFFFF);
      tick();

      // Out of range on both ports, last valid index, index 0 untouched
      drive(1'b0, 32'h0, 1'b1, 32'h0, 32'h01234567, 4'hF);
      drive(1'b1, 32'h1000, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
      check("t4 ready0", 32'(ready0), 32'd1);
      check("t4 err0", 32'(err0), 32'd1);
      check("t4 rdata0 zero", rdata0, 32'd0);
      check("t4 pb_ready0", 32'(pb_ready0), 32'd1);
      check("t4 pb_err0", 32'(pb_err0), 32'd1);
      check("t4 pb_err1", 32'(pb_err1), 32'd1);
      check("t4 err1 early", 32'(err1), 32'd0);
      tick();
      check("t4 ready1", 32'(ready1), 32'd1);
      check("t4 err1", 32'(err1), 32'd1);
      check("t4 rdata1 zero", rdata1, 32'd0);
      check("t4 err0 qualified", 32'(err0), 32'd0);
      check("t4 pb_err0 pulse", 32'(pb_err0), 32'd0);
      drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
      check("t4 idx0 rdata0", rdata0, 32'h01234567);
      check("t4 idx0 err0", 32'(err0), 32'd0);
      tick();
      check("t4 idx0 rdata1", rdata1, 32'h01234567);
      drive(1'b0, 32'h0, 1'b1, 32'hFFC, 32'h3FF3FF00, 4'hF);
      check("t4 last pb_err0", 32'(pb_err0), 32'd0);
      drive(1'b1, 32'hFFC, 1'b0, 32'h0, 32'h0, 4'h0);
      check("t4 last err0", 32'(err0), 32'd0);
      check("t4 last rdata0", rdata0, 32'h3FF3FF00);
      tick();

      // Back-to-back read burst
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 32'h0, 1'b1, 32'(i * 4), 32'hB0000000 + 32'(i), 4'hF);
      end
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) drive(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0, 4'h0);
         else tick();
         if (i < 16) begin
            check("t5 ready0", 32'(ready0), 32'd1);
            check("t5 rdata0", rdata0, 32'hB0000000 + 32'(i));
         end
         if (i == 0) begin
            check("t5 ready1 first", 32'(ready1), 32'd0);
         end else begin
            check("t5 ready1", 32'(ready1), 32'd1);
            check("t5 rdata1", rdata1, 32'hB0000000 + 32'(i - 1));
         end
      end
      tick();
      check("t5 ready1 end", 32'(ready1), 32'd0);

      // Reset mid-burst
      drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
      pa_req  = 1'b1;
      pa_addr = 32'h4;
      tick();
      pa_addr = 32'h8;
      #2 rst_n = 1'b0;
      #1;
      check("t6 rst ready0", 32'(ready0), 32'd0);
      check("t6 rst ready1", 32'(ready1), 32'd0);
      check("t6 rst rdata0", rdata0, 32'd0);
      check("t6 rst rdata1", rdata1, 32'd0);
      pb_req   = 1'b1;
      pb_addr  = 32'h0;
      pb_wdata = 32'h0;
      pb_be    = 4'hF;
      tick();
      check("t6 in rst ready0", 32'(ready0), 32'd0);
      check("t6 in rst pb_ready0", 32'(pb_ready0), 32'd0);
      pa_req = 1'b0;
      pb_req = 1'b0;
      #3 rst_n = 1'b1;
      tick();
      check("t6 dropped ready0", 32'(ready0), 32'd0);
      check("t6 dropped ready1", 32'(ready1), 32'd0);
      check("t6 dropped pb_ready0", 32'(pb_ready0), 32'd0);
      tick();
      check("t6 dropped ready1 late", 32'(ready1), 32'd0);
      drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
      check("t6 kept rdata0", rdata0, 32'hB0000000);
      tick();
      check("t6 kept rdata1", rdata1, 32'hB0000000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
